// File: rtl/resp_arb.sv
// Two-requester packet arbiter feeding the shared SRIO tresp stream.
// A granted requester owns the output until its tlast beat transfers; round-robin between packets.
module resp_arb #(
    parameter int CNT_W = 16
) (
    input  logic             log_clk,
    input  logic             log_rst,
    input  logic             s0_tvalid,
    input  logic             s0_tlast,
    input  logic [63:0]      s0_tdata,
    input  logic [7:0]       s0_tkeep,
    input  logic [31:0]      s0_tuser,
    output logic             s0_tready,
    input  logic             s1_tvalid,
    input  logic             s1_tlast,
    input  logic [63:0]      s1_tdata,
    input  logic [7:0]       s1_tkeep,
    input  logic [31:0]      s1_tuser,
    output logic             s1_tready,
    output logic             m_tvalid,
    output logic             m_tlast,
    output logic [63:0]      m_tdata,
    output logic [7:0]       m_tkeep,
    output logic [31:0]      m_tuser,
    input  logic             m_tready,
    output logic [1:0]       grant,
    output logic [CNT_W-1:0] pkt_cnt0,
    output logic [CNT_W-1:0] pkt_cnt1
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } state_t;

    state_t           state_reg;
    logic             prio_reg;
    logic [1:0]       src_last;
    logic [1:0]       pkt_done;
    logic             beat_xfer;
    logic [CNT_W-1:0] cnt_out [2];

    assign src_last  = {s1_tlast, s0_tlast};
    assign beat_xfer = m_tvalid && m_tready;

    always_comb begin
        grant = 2'b00;
        case (state_reg)
            LOCK0:   grant = 2'b01;
            LOCK1:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
    end

    // Output mux is purely combinational from the registered owner, so the
    // source keeps full AXI-stream handshake semantics through the arbiter.
    always_comb begin
        m_tvalid  = 1'b0;
        m_tlast   = 1'b0;
        m_tdata   = '0;
        m_tkeep   = '0;
        m_tuser   = '0;
        s0_tready = 1'b0;
        s1_tready = 1'b0;
        case (state_reg)
            LOCK0: begin
                m_tvalid  = s0_tvalid;
                m_tlast   = s0_tlast;
                m_tdata   = s0_tdata;
                m_tkeep   = s0_tkeep;
                m_tuser   = s0_tuser;
                s0_tready = m_tready;
            end
            LOCK1: begin
                m_tvalid  = s1_tvalid;
                m_tlast   = s1_tlast;
                m_tdata   = s1_tdata;
                m_tkeep   = s1_tkeep;
                m_tuser   = s1_tuser;
                s1_tready = m_tready;
            end
            default: ;
        endcase
    end

    always_ff @(posedge log_clk or posedge log_rst) begin
        if (log_rst) begin
            state_reg <= IDLE;
            prio_reg  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (s0_tvalid && (!s1_tvalid || !prio_reg))
                        state_reg <= LOCK0;
                    else if (s1_tvalid)
                        state_reg <= LOCK1;
                end
                LOCK0: begin
                    if (pkt_done[0]) begin
                        state_reg <= IDLE;
                        prio_reg  <= 1'b1;
                    end
                end
                LOCK1: begin
                    if (pkt_done[1]) begin
                        state_reg <= IDLE;
                        prio_reg  <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    // Per-requester completion counters; free-running wrap is intended.
    for (genvar gi = 0; gi < 2; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_reg;

        assign pkt_done[gi] = grant[gi] && beat_xfer && src_last[gi];
        assign cnt_out[gi]  = cnt_reg;

        always_ff @(posedge log_clk or posedge log_rst) begin
            if (log_rst)
                cnt_reg <= '0;
            else if (pkt_done[gi])
                cnt_reg <= cnt_reg + 1'b1;
        end
    end

    assign pkt_cnt0 = cnt_out[0];
    assign pkt_cnt1 = cnt_out[1];

endmodule

// File: tb/tb_resp_arb.sv
// Bench for resp_arb: queue-driven sources, a packet-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_resp_arb;

    localparam int CNT_W = 4;

    typedef struct {
        logic        bub;
        logic [63:0] d;
        logic [7:0]  k;
        logic [31:0] u;
        logic        l;
    } beat_t;

    logic             log_clk = 1'b0;
    logic             log_rst = 1'b1;
    logic [1:0]       sv;
    logic [1:0]       sl;
    logic [63:0]      sd [2];
    logic [7:0]       sk [2];
    logic [31:0]      su [2];
    wire              s0_tready_w;
    wire              s1_tready_w;
    wire  [1:0]       sr = {s1_tready_w, s0_tready_w};
    logic             m_tvalid, m_tlast;
    logic [63:0]      m_tdata;
    logic [7:0]       m_tkeep;
    logic [31:0]      m_tuser;
    logic             m_tready = 1'b1;
    logic [1:0]       grant;
    logic [CNT_W-1:0] pkt_cnt0, pkt_cnt1;

    beat_t srcq [2][$];
    int    tests = 0;
    int    fails = 0;
    int    dut_beats = 0;
    int    done_order[$];

    always #5 log_clk = ~log_clk;

    resp_arb #(.CNT_W(CNT_W)) dut (
        .log_clk  (log_clk),
        .log_rst  (log_rst),
        .s0_tvalid(sv[0]),
        .s0_tlast (sl[0]),
        .s0_tdata (sd[0]),
        .s0_tkeep (sk[0]),
        .s0_tuser (su[0]),
        .s0_tready(s0_tready_w),
        .s1_tvalid(sv[1]),
        .s1_tlast (sl[1]),
        .s1_tdata (sd[1]),
        .s1_tkeep (sk[1]),
        .s1_tuser (su[1]),
        .s1_tready(s1_tready_w),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tdata  (m_tdata),
        .m_tkeep  (m_tkeep),
        .m_tuser  (m_tuser),
        .m_tready (m_tready),
        .grant    (grant),
        .pkt_cnt0 (pkt_cnt0),
        .pkt_cnt1 (pkt_cnt1)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge log_clk);
        #2;
    endtask

    // Source drivers: a beat stays presented until it transfers; bubble entries idle one cycle.
    initial begin
        logic [1:0] xfer;
        sv = '0;
        sl = '0;
        for (int i = 0; i < 2; i++) begin
            sd[i] = '0;
            sk[i] = '0;
            su[i] = '0;
        end
        forever begin
            @(negedge log_clk);
            xfer = sv & sr & {2{!log_rst}};
            @(posedge log_clk);
            #1;
            for (int i = 0; i < 2; i++) begin
                if (xfer[i] && srcq[i].size() > 0)
                    void'(srcq[i].pop_front());
                if (srcq[i].size() > 0 && !srcq[i][0].bub) begin
                    sv[i] = 1'b1;
                    sl[i] = srcq[i][0].l;
                    sd[i] = srcq[i][0].d;
                    sk[i] = srcq[i][0].k;
                    su[i] = srcq[i][0].u;
                end else begin
                    sv[i] = 1'b0;
                    sl[i] = 1'b0;
                    sd[i] = '0;
                    sk[i] = '0;
                    su[i] = '0;
                    if (srcq[i].size() > 0)
                        void'(srcq[i].pop_front());
                end
            end
        end
    end

    // Reference model: owner of the stream (-1 = none), fairness pointer, packet totals.
    initial begin
        int          owner;
        int          fav;
        int          cnt_m [2];
        logic        e_v, e_l;
        logic [63:0] e_d;
        logic [7:0]  e_k;
        logic [31:0] e_u;
        logic [1:0]  e_tr, e_g;
        owner = -1;
        fav = 0;
        cnt_m[0] = 0;
        cnt_m[1] = 0;
        forever begin
            @(negedge log_clk);
            if (log_rst) begin
                owner = -1;
                fav = 0;
                cnt_m[0] = 0;
                cnt_m[1] = 0;
            end
            e_v = 1'b0; e_l = 1'b0; e_d = '0; e_k = '0; e_u = '0; e_tr = 2'b00; e_g = 2'b00;
            if (owner >= 0) begin
                e_v = sv[owner];
                e_l = sl[owner];
                e_d = sd[owner];
                e_k = sk[owner];
                e_u = su[owner];
                e_tr[owner] = m_tready;
                e_g[owner] = 1'b1;
            end
            chk("m_tvalid", 64'(m_tvalid), 64'(e_v));
            chk("m_tlast", 64'(m_tlast), 64'(e_l));
            chk("m_tdata", m_tdata, e_d);
            chk("m_tkeep", 64'(m_tkeep), 64'(e_k));
            chk("m_tuser", 64'(m_tuser), 64'(e_u));
            chk("s_tready", 64'(sr), 64'(e_tr));
            chk("grant", 64'(grant), 64'(e_g));
            chk("pkt_cnt0", 64'(pkt_cnt0), 64'(cnt_m[0]));
            chk("pkt_cnt1", 64'(pkt_cnt1), 64'(cnt_m[1]));
            if (!log_rst) begin
                if (m_tvalid && m_tready) begin
                    dut_beats++;
                    $display("[TB] beat grant=%b data=%h keep=%h user=%h last=%b",
                             grant, m_tdata, m_tkeep, m_tuser, m_tlast);
                    if (m_tlast)
                        done_order.push_back(grant == 2'b10 ? 1 : 0);
                end
                if (owner < 0) begin
                    if (sv[0] && (!sv[1] || fav == 0))
                        owner = 0;
                    else if (sv[1])
                        owner = 1;
                end else if (sv[owner] && m_tready && sl[owner]) begin
                    cnt_m[owner] = (cnt_m[owner] + 1) % (1 << CNT_W);
                    fav = 1 - owner;
                    owner = -1;
                end
            end
        end
    end

    task automatic push_pkt(input int src, input int nbeats, input logic [63:0] base,
                            input int bub_at, input int bub_len);
        beat_t b;
        for (int j = 0; j < nbeats; j++) begin
            if (j == bub_at) begin
                for (int g = 0; g < bub_len; g++) begin
                    b.bub = 1'b1; b.d = '0; b.k = '0; b.u = '0; b.l = 1'b0;
                    srcq[src].push_back(b);
                end
            end
            b.bub = 1'b0;
            b.d = base + 64'(j);
            b.k = 8'hFF - 8'(j);
            b.u = 32'h0010_0020 + 32'(src);
            b.l = (j == nbeats - 1);
            srcq[src].push_back(b);
        end
    endtask

    task automatic do_reset();
        log_rst = 1'b1;
        srcq[0].delete();
        srcq[1].delete();
        repeat (2) tick();
        log_rst = 1'b0;
        dut_beats = 0;
        done_order.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((srcq[0].size() > 0 || srcq[1].size() > 0 || grant != 2'b00) && n < budget) begin
            tick();
            n++;
        end
        chk("idle_timeout", 64'(n >= budget), 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_grant", 64'(grant), 64'd0);
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_cnt0", 64'(pkt_cnt0), 64'd0);
        chk("rst_tready", 64'(sr), 64'd0);
        do_reset();

        // Single doorbell from s0.
        push_pkt(0, 1, 64'h00A0_2000_0100_0000, -1, 0);
        tick();
        chk("db_decide_valid", 64'(m_tvalid), 64'd0);
        chk("db_decide_grant", 64'(grant), 64'd0);
        tick();
        chk("db_valid", 64'(m_tvalid), 64'd1);
        chk("db_data", m_tdata, 64'h00A0_2000_0100_0000);
        chk("db_grant", 64'(grant), 64'd1);
        tick();
        chk("db_valid_off", 64'(m_tvalid), 64'd0);
        chk("db_grant_off", 64'(grant), 64'd0);
        chk("db_cnt0", 64'(pkt_cnt0), 64'd1);
        chk("db_beats", 64'(dut_beats), 64'd1);

        // Simultaneous single-beat requests alternate.
        do_reset();
        push_pkt(0, 1, 64'h1000, -1, 0);
        push_pkt(0, 1, 64'h1100, -1, 0);
        push_pkt(1, 1, 64'h2000, -1, 0);
        push_pkt(1, 1, 64'h2100, -1, 0);
        wait_idle(40);
        chk("rr_count", 64'(done_order.size()), 64'd4);
        if (done_order.size() == 4) begin
            chk("rr_0", 64'(done_order[0]), 64'd0);
            chk("rr_1", 64'(done_order[1]), 64'd1);
            chk("rr_2", 64'(done_order[2]), 64'd0);
            chk("rr_3", 64'(done_order[3]), 64'd1);
        end

        // s1 holds the stream for its whole 4-beat packet while s0 waits.
        do_reset();
        push_pkt(1, 4, 64'h3000, -1, 0);
        push_pkt(0, 1, 64'h4000, 0, 2);
        wait_idle(40);
        chk("lock_beats", 64'(dut_beats), 64'd5);
        chk("lock_count", 64'(done_order.size()), 64'd2);
        if (done_order.size() == 2) begin
            chk("lock_first", 64'(done_order[0]), 64'd1);
            chk("lock_second", 64'(done_order[1]), 64'd0);
        end

        // Backpressure plus source bubble keeps LOCK0.
        do_reset();
        push_pkt(0, 4, 64'h5000, 2, 2);
        tick();
        tick();
        m_tready = 1'b0;
        repeat (3) begin
            tick();
            chk("bp_grant", 64'(grant), 64'd1);
        end
        m_tready = 1'b1;
        wait_idle(40);
        chk("bp_beats", 64'(dut_beats), 64'd4);
        chk("bp_cnt0", 64'(pkt_cnt0), 64'd1);

        // Reset mid-packet abandons it and clears priority and counters.
        do_reset();
        push_pkt(1, 1, 64'h6000, -1, 0);
        wait_idle(20);
        chk("mr_cnt1_pre", 64'(pkt_cnt1), 64'd1);
        push_pkt(0, 4, 64'h7000, -1, 0);
        tick();
        tick();
        tick();
        chk("mr_grant_pre", 64'(grant), 64'd1);
        log_rst = 1'b1;
        #1;
        chk("mr_valid", 64'(m_tvalid), 64'd0);
        chk("mr_grant", 64'(grant), 64'd0);
        chk("mr_cnt1", 64'(pkt_cnt1), 64'd0);
        do_reset();
        push_pkt(0, 1, 64'h8000, -1, 0);
        push_pkt(1, 1, 64'h9000, -1, 0);
        tick();
        chk("mr_lat_valid", 64'(m_tvalid), 64'd0);
        tick();
        chk("mr_lat_grant", 64'(grant), 64'd1);
        chk("mr_lat_data", m_tdata, 64'h8000);
        wait_idle(20);
        if (done_order.size() == 2)
            chk("mr_second", 64'(done_order[1]), 64'd1);
        else
            chk("mr_order_len", 64'(done_order.size()), 64'd2);

        // Counter wrap with 4-bit counters.
        do_reset();
        for (int p = 0; p < 17; p++)
            push_pkt(1, 1, 64'hA000 + 64'(p), -1, 0);
        wait_idle(100);
        chk("wrap_cnt1", 64'(pkt_cnt1), 64'd1);
        chk("wrap_pkts", 64'(done_order.size()), 64'd17);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
